// File: rtl/ult_argmin_pkg.sv
// Shared types and helpers for the streaming arg-min controller.
package ult_argmin_pkg;

  // Controller states: waiting for the first beat, scanning, and holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width needed to address max_len beats.
  function automatic int idx_width(input int max_len);
    return $clog2(max_len);
  endfunction

endpackage

// File: rtl/ult_cmp.sv
// Combinational unsigned less-than: out = in0 < in1, no sign extension.
module ult_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out
);

  assign out = (in0 < in1);

endmodule

// File: rtl/ult_argmin_seq.sv
// Streaming arg-min sequencer around a shared unsigned less-than comparator.
// Accepts one beat per cycle, tracks the running minimum and the index of its
// first occurrence, then presents min/index/length on a valid/ready output.
// Optional macro ULT_TRACK_MAX_EN adds first-occurrence maximum tracking
// (O_max / O_max_idx) through a second comparator.
module ult_argmin_seq
  import ult_argmin_pkg::*;
#(
  parameter int  WIDTH     = 4,
  parameter int  MAX_LEN   = 16,
  localparam int IDX_WIDTH = idx_width(MAX_LEN)
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESET,
  input  logic                 I_valid,
  input  logic [WIDTH-1:0]     I_data,
  input  logic                 I_last,
  output logic                 I_ready,
  output logic                 O_valid,
  output logic [WIDTH-1:0]     O_min,
  output logic [IDX_WIDTH-1:0] O_idx,
  output logic [IDX_WIDTH:0]   O_len,
`ifdef ULT_TRACK_MAX_EN
  output logic [WIDTH-1:0]     O_max,
  output logic [IDX_WIDTH-1:0] O_max_idx,
`endif
  input  logic                 O_ready
);

  // A sequence is forced to end when the MAX_LEN-th beat arrives in SCAN.
  localparam logic [IDX_WIDTH:0] LAST_CNT = (IDX_WIDTH+1)'(MAX_LEN - 1);

  state_t                 state_reg;
  logic [WIDTH-1:0]       min_reg, min_next;
  logic [IDX_WIDTH-1:0]   idx_reg, idx_next;
  logic [IDX_WIDTH:0]     cnt_reg, cnt_next;
  logic                   seq_end;
  logic                   beat_acc;
  logic                   min_lt;

  assign I_ready  = (state_reg != DONE);
  assign beat_acc = I_valid & I_ready;

  ult_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .in0 (I_data),
    .in1 (min_reg),
    .out (min_lt)
  );

`ifdef ULT_TRACK_MAX_EN
  logic [WIDTH-1:0]     max_reg, max_next;
  logic [IDX_WIDTH-1:0] max_idx_reg, max_idx_next;
  logic                 max_gt;

  ult_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .in0 (max_reg),
    .in1 (I_data),
    .out (max_gt)
  );

  // Running max candidate for the current beat; strict compare keeps the first occurrence.
  always_comb begin
    max_next     = max_reg;
    max_idx_next = max_idx_reg;
    if (state_reg == IDLE) begin
      max_next     = I_data;
      max_idx_next = '0;
    end else if (max_gt) begin
      max_next     = I_data;
      max_idx_next = cnt_reg[IDX_WIDTH-1:0];
    end
  end
`endif

  // Running min candidate, beat count and end-of-sequence decision for the current beat.
  always_comb begin
    min_next = min_reg;
    idx_next = idx_reg;
    cnt_next = cnt_reg;
    seq_end  = 1'b0;
    if (state_reg == IDLE) begin
      min_next = I_data;
      idx_next = '0;
      cnt_next = (IDX_WIDTH+1)'(1);
      seq_end  = I_last;
    end else begin
      if (min_lt) begin
        min_next = I_data;
        idx_next = cnt_reg[IDX_WIDTH-1:0];
      end
      cnt_next = cnt_reg + 1'b1;
      seq_end  = I_last | (cnt_reg == LAST_CNT);
    end
  end

  // FSM plus running state and registered result outputs.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_reg   <= IDLE;
      min_reg     <= '0;
      idx_reg     <= '0;
      cnt_reg     <= '0;
      O_valid     <= 1'b0;
      O_min       <= '0;
      O_idx       <= '0;
      O_len       <= '0;
`ifdef ULT_TRACK_MAX_EN
      max_reg     <= '0;
      max_idx_reg <= '0;
      O_max       <= '0;
      O_max_idx   <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE, SCAN: begin
          if (beat_acc) begin
            min_reg <= min_next;
            idx_reg <= idx_next;
            cnt_reg <= cnt_next;
`ifdef ULT_TRACK_MAX_EN
            max_reg     <= max_next;
            max_idx_reg <= max_idx_next;
`endif
            if (seq_end) begin
              state_reg <= DONE;
              O_valid   <= 1'b1;
              O_min     <= min_next;
              O_idx     <= idx_next;
              O_len     <= cnt_next;
`ifdef ULT_TRACK_MAX_EN
              O_max     <= max_next;
              O_max_idx <= max_idx_next;
`endif
            end else begin
              state_reg <= SCAN;
            end
          end
        end
        DONE: begin
          if (O_ready) begin
            state_reg <= IDLE;
            O_valid   <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          O_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ult_argmin_seq.sv
// Directed self-checking bench for ult_argmin_seq (WIDTH=4, MAX_LEN=16).
module tb_ult_argmin_seq;

  localparam int WIDTH     = 4;
  localparam int MAX_LEN   = 16;
  localparam int IDX_WIDTH = 4;

  logic                 CLK;
  logic                 ASYNCRESET;
  logic                 I_valid;
  logic [WIDTH-1:0]     I_data;
  logic                 I_last;
  logic                 I_ready;
  logic                 O_valid;
  logic [WIDTH-1:0]     O_min;
  logic [IDX_WIDTH-1:0] O_idx;
  logic [IDX_WIDTH:0]   O_len;
  logic                 O_ready;
`ifdef ULT_TRACK_MAX_EN
  logic [WIDTH-1:0]     O_max;
  logic [IDX_WIDTH-1:0] O_max_idx;
`endif

  int checks = 0;
  int errors = 0;

  ult_argmin_seq #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .I_valid    (I_valid),
    .I_data     (I_data),
    .I_last     (I_last),
    .I_ready    (I_ready),
    .O_valid    (O_valid),
    .O_min      (O_min),
    .O_idx      (O_idx),
    .O_len      (O_len),
`ifdef ULT_TRACK_MAX_EN
    .O_max      (O_max),
    .O_max_idx  (O_max_idx),
`endif
    .O_ready    (O_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
    $display("check %s observed=%0d expected=%0d", tag, obs, exp_v);
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic l);
    I_valid = v;
    I_data  = d;
    I_last  = l;
  endtask

  // One clock: inputs seen at the posedge, outputs sampled at the following negedge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    I_valid    = 1'b0;
    I_data     = '0;
    I_last     = 1'b0;
    O_ready    = 1'b0;
    ASYNCRESET = 1'b1;
    repeat (3) @(negedge CLK);

    // Reset state
    chk("rst_o_valid", 32'(O_valid), 0);
    chk("rst_i_ready", 32'(I_ready), 1);
    chk("rst_o_min",   32'(O_min),   0);
    chk("rst_o_idx",   32'(O_idx),   0);
    chk("rst_o_len",   32'(O_len),   0);
    ASYNCRESET = 1'b0;
    step();

    // 9,3,7,3,12: tie on 3 keeps index 1
    O_ready = 1'b1;
    drive(1, 9, 0); step();
    drive(1, 3, 0); step();
    drive(1, 7, 0); step();
    drive(1, 3, 0); step();
    chk("t1_no_valid_early", 32'(O_valid), 0);
    drive(1, 12, 1); step();
    chk("t1_o_valid", 32'(O_valid), 1);
    chk("t1_o_min",   32'(O_min),   3);
    chk("t1_o_idx",   32'(O_idx),   1);
    chk("t1_o_len",   32'(O_len),   5);
    chk("t1_i_ready", 32'(I_ready), 0);
    drive(0, 0, 0); step();
    chk("t1_valid_drop", 32'(O_valid), 0);
    chk("t1_i_ready_back", 32'(I_ready), 1);
    chk("t1_min_held", 32'(O_min), 3);

    // Single beat sequence
    drive(1, 6, 1); step();
    chk("t2_o_valid", 32'(O_valid), 1);
    chk("t2_o_min",   32'(O_min),   6);
    chk("t2_o_idx",   32'(O_idx),   0);
    chk("t2_o_len",   32'(O_len),   1);
    chk("t2_i_ready", 32'(I_ready), 0);
    drive(0, 0, 0); step();

    // 15..0 without I_last: MAX_LEN beats force the end
    O_ready = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      drive(1, 4'(15 - i), 0);
      step();
    end
    chk("t3_o_valid", 32'(O_valid), 1);
    chk("t3_o_min",   32'(O_min),   0);
    chk("t3_o_idx",   32'(O_idx),   15);
    chk("t3_o_len",   32'(O_len),   16);
    chk("t3_i_ready", 32'(I_ready), 0);
    // 17th beat offered while DONE must be held, then taken as a new sequence
    drive(1, 3, 1); step();
    chk("t3_held_ready", 32'(I_ready), 0);
    chk("t3_held_min",   32'(O_min),   0);
    O_ready = 1'b1; step();
    chk("t3_handoff_valid", 32'(O_valid), 0);
    chk("t3_handoff_ready", 32'(I_ready), 1);
    step();
    chk("t3_17th_valid", 32'(O_valid), 1);
    chk("t3_17th_min",   32'(O_min),   3);
    chk("t3_17th_len",   32'(O_len),   1);
    drive(0, 0, 0); step();

    // 5,_,2,_,_,8 with O_ready held low for 3 cycles
    O_ready = 1'b0;
    drive(1, 5, 0); step();
    drive(0, 0, 0); step();
    drive(1, 2, 0); step();
    drive(0, 0, 0); step();
    drive(0, 0, 0); step();
    drive(1, 8, 1); step();
    drive(0, 0, 0);
    chk("t4_o_len", 32'(O_len), 3);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("t4_stall%0d_valid", c), 32'(O_valid), 1);
      chk($sformatf("t4_stall%0d_min", c),   32'(O_min),   2);
      chk($sformatf("t4_stall%0d_idx", c),   32'(O_idx),   1);
      if (c < 2) step();
    end
    O_ready = 1'b1; step();
    chk("t4_valid_drop", 32'(O_valid), 0);

    // Asynchronous reset between edges after beats 4,1
    drive(1, 4, 0); step();
    drive(1, 1, 0); step();
    drive(0, 0, 0);
    #2 ASYNCRESET = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(O_valid), 0);
    chk("t5_rst_ready", 32'(I_ready), 1);
    chk("t5_rst_min",   32'(O_min),   0);
    chk("t5_rst_len",   32'(O_len),   0);
    @(negedge CLK);
    ASYNCRESET = 1'b0;
    drive(1, 7, 0); step();
    drive(1, 9, 1); step();
    chk("t5_o_valid", 32'(O_valid), 1);
    chk("t5_o_min",   32'(O_min),   7);
    chk("t5_o_idx",   32'(O_idx),   0);
    chk("t5_o_len",   32'(O_len),   2);
    drive(0, 0, 0); step();

    // 2,14,14,0: min at the end, max first occurrence at index 1
    drive(1, 2, 0);  step();
    drive(1, 14, 0); step();
    drive(1, 14, 0); step();
    drive(1, 0, 1);  step();
    chk("t6_o_valid", 32'(O_valid), 1);
    chk("t6_o_min",   32'(O_min),   0);
    chk("t6_o_idx",   32'(O_idx),   3);
    chk("t6_o_len",   32'(O_len),   4);
`ifdef ULT_TRACK_MAX_EN
    chk("t6_o_max",     32'(O_max),     14);
    chk("t6_o_max_idx", 32'(O_max_idx), 1);
`endif
    drive(0, 0, 0); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
